spi_frame_rx: RTL and testbench

- Parametrised successor to the fixed 51-byte MCU-DMA SPI receiver.
- Oversamples SCLK/CS/MOSI in the CLK domain and assembles a frame of FRAME_BYTES bytes in any SPI mode.
- Validates frame length and presents the frame through a valid/ack hold register, with overrun and error accounting.
- Sits between the MCU SPI pins and the real-time command register (wcm).

---
 rtl/spi_frame_rx.sv | 126 ++++++++++++
 tb/tb_spi_frame_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI frame receiver with valid/ack hold register; define SPI_FRAME_CRC_EN to append and check a trailing CRC-8 byte
module spi_frame_rx #(
  parameter int FRAME_BYTES = 51,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SCLK,
  input  logic                     CS,
  input  logic                     MOSI,
  output logic [FRAME_BYTES*8-1:0] FRAME_DATA,
  output logic                     FRAME_VALID,
  input  logic                     FRAME_ACK,
  output logic                     ERR_LEN,
  output logic                     ERR_OVR,
  output logic                     ERR_CRC,
  output logic [15:0]              FRAME_CNT,
  output logic [ERR_CNT_W-1:0]     ERR_CNT
);
  localparam int PAY_BITS = FRAME_BYTES * 8;
`ifdef SPI_FRAME_CRC_EN
  localparam int FRAME_BITS = PAY_BITS + 8;
`else
  localparam int FRAME_BITS = PAY_BITS;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(FRAME_BITS + 1);
  localparam logic [1:0] ARM = 2'd0, IDLE = 2'd1, RX = 2'd2, EVAL = 2'd3;

  logic [2:0] sclkSync, csSync;
  logic [1:0] mosiSync;
  logic [1:0] state;
  logic [FRAME_BITS-1:0] shiftReg;
  logic [CNT_W-1:0] bitCnt;
  logic fallPend, sampleEdge, csRise, csFall, startRx, shiftIn, lenOk, crcBad;
  logic doLen, doOvr, doCrc, doLoad;

  // bring the asynchronous SPI pins into the CLK domain; stage 2 of SCLK/CS only feeds edge detection
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sclkSync <= '0;
      csSync   <= '0;
      mosiSync <= '0;
    end else begin
      sclkSync <= {sclkSync[1:0], SCLK};
      csSync   <= {csSync[1:0], CS};
      mosiSync <= {mosiSync[0], MOSI};
    end

  assign sampleEdge = (CPOL == CPHA) ? (sclkSync[1] & ~sclkSync[2]) : (~sclkSync[1] & sclkSync[2]);
  assign csRise = csSync[1] & ~csSync[2];
  assign csFall = ~csSync[1] & csSync[2];
  assign startRx = (state == IDLE) && (csFall || fallPend);
  assign shiftIn = (state == RX) && sampleEdge && (bitCnt < FULL);
  assign lenOk = bitCnt == FULL;

`ifdef SPI_FRAME_CRC_EN
  localparam logic [CNT_W-1:0] PAY_CNT = CNT_W'(PAY_BITS);
  logic [7:0] crc, crcNext;
  assign crcNext = {crc[6:0], 1'b0} ^ ((crc[7] ^ mosiSync[1]) ? 8'h07 : 8'h00);
  assign crcBad = crc != shiftReg[7:0];

  // running CRC-8 over the payload bits only; the trailing byte is compared against it
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) crc <= '0;
    else if (startRx) crc <= '0;
    else if (shiftIn && bitCnt < PAY_CNT) crc <= crcNext;
`else
  assign crcBad = 1'b0;
`endif

  assign doLen  = (state == EVAL) && (bitCnt != '0) && !lenOk;
  assign doCrc  = (state == EVAL) && lenOk && crcBad;
  assign doOvr  = (state == EVAL) && lenOk && !crcBad && FRAME_VALID && !FRAME_ACK;
  assign doLoad = (state == EVAL) && lenOk && !crcBad && !(FRAME_VALID && !FRAME_ACK);

  // frame sequencing: ARM blocks a frame already in flight at reset release
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state    <= ARM;
      shiftReg <= '0;
      bitCnt   <= '0;
      fallPend <= 1'b0;
    end else begin
      fallPend <= (state == EVAL) && csFall;
      case (state)
        ARM:  if (csSync[1]) state <= IDLE;
        IDLE: if (startRx) begin
          state    <= RX;
          shiftReg <= '0;
          bitCnt   <= '0;
        end
        RX: begin
          if (csRise) state <= EVAL;
          if (shiftIn) begin
            shiftReg <= {shiftReg[FRAME_BITS-2:0], mosiSync[1]};
            bitCnt   <= bitCnt + CNT_W'(1);
          end else if (sampleEdge && lenOk) bitCnt <= SAT;
        end
        default: state <= IDLE;
      endcase
    end

  // hold register, one-cycle error pulses and event counters
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      FRAME_DATA  <= '0;
      FRAME_VALID <= 1'b0;
      ERR_LEN     <= 1'b0;
      ERR_OVR     <= 1'b0;
      ERR_CRC     <= 1'b0;
      FRAME_CNT   <= '0;
      ERR_CNT     <= '0;
    end else begin
      ERR_LEN     <= doLen;
      ERR_OVR     <= doOvr;
      ERR_CRC     <= doCrc;
      FRAME_VALID <= doLoad | (FRAME_VALID & ~FRAME_ACK);
      if (doLoad) FRAME_DATA <= shiftReg[FRAME_BITS-1 -: PAY_BITS];
      if (doLoad) FRAME_CNT <= FRAME_CNT + 16'd1;
      if ((doLen || doOvr || doCrc) && !(&ERR_CNT)) ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
    end
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed frames into four receivers (modes 0, 3, 1 and a 2-byte build), checked by a scoreboard monitor
module tb_spi_frame_rx;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sclk[4], cs[4], mosi[4], ack[4];
  logic fvalid[4], elen[4], eovr[4], ecrc[4];
  logic [15:0] fcnt[4], prevCnt[4];
  logic [7:0] ecnt[4];
  logic [511:0] fdata[4];
  logic [407:0] fd0, fd1, fd2;
  logic [15:0] fd3;
  assign fdata[0] = 512'(fd0);
  assign fdata[1] = 512'(fd1);
  assign fdata[2] = 512'(fd2);
  assign fdata[3] = 512'(fd3);
  int cpol[4] = '{0, 1, 0, 0};
  int cpha[4] = '{0, 1, 1, 0};

  spi_frame_rx #(.FRAME_BYTES(51), .CPOL(0), .CPHA(0), .ERR_CNT_W(8)) u0 (.CLK(clk), .RESET(rst), .SCLK(sclk[0]), .CS(cs[0]), .MOSI(mosi[0]),
    .FRAME_DATA(fd0), .FRAME_VALID(fvalid[0]), .FRAME_ACK(ack[0]), .ERR_LEN(elen[0]), .ERR_OVR(eovr[0]), .ERR_CRC(ecrc[0]), .FRAME_CNT(fcnt[0]), .ERR_CNT(ecnt[0]));
  spi_frame_rx #(.FRAME_BYTES(51), .CPOL(1), .CPHA(1), .ERR_CNT_W(8)) u1 (.CLK(clk), .RESET(rst), .SCLK(sclk[1]), .CS(cs[1]), .MOSI(mosi[1]),
    .FRAME_DATA(fd1), .FRAME_VALID(fvalid[1]), .FRAME_ACK(ack[1]), .ERR_LEN(elen[1]), .ERR_OVR(eovr[1]), .ERR_CRC(ecrc[1]), .FRAME_CNT(fcnt[1]), .ERR_CNT(ecnt[1]));
  spi_frame_rx #(.FRAME_BYTES(51), .CPOL(0), .CPHA(1), .ERR_CNT_W(8)) u2 (.CLK(clk), .RESET(rst), .SCLK(sclk[2]), .CS(cs[2]), .MOSI(mosi[2]),
    .FRAME_DATA(fd2), .FRAME_VALID(fvalid[2]), .FRAME_ACK(ack[2]), .ERR_LEN(elen[2]), .ERR_OVR(eovr[2]), .ERR_CRC(ecrc[2]), .FRAME_CNT(fcnt[2]), .ERR_CNT(ecnt[2]));
  spi_frame_rx #(.FRAME_BYTES(2), .CPOL(0), .CPHA(0), .ERR_CNT_W(8)) u3 (.CLK(clk), .RESET(rst), .SCLK(sclk[3]), .CS(cs[3]), .MOSI(mosi[3]),
    .FRAME_DATA(fd3), .FRAME_VALID(fvalid[3]), .FRAME_ACK(ack[3]), .ERR_LEN(elen[3]), .ERR_OVR(eovr[3]), .ERR_CRC(ecrc[3]), .FRAME_CNT(fcnt[3]), .ERR_CNT(ecnt[3]));

  typedef struct {
    int inst;
    int kind;
    logic [511:0] data;
    int fc;
    int ec;
    int due;
    bit valid;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int kind;
  int nChecks = 0, nFails = 0;
  int expFc[4], expEc[4];
  bit expValid[4];
  logic [511:0] expData[4];

  localparam logic [407:0] T1 = {64'h1, 48'h280000000000, 48'h2cbd3f, 32'd1, 64'd480000, 32'd10, 8'd0,
                                 32'd4800, 32'd4800, 24'd480, 24'd480};
  localparam logic [407:0] FA = {51{8'h3C}};
  localparam logic [407:0] FB = {17{24'h123456}};
  localparam logic [407:0] FC = {51{8'hC3}};
  localparam logic [407:0] F5 = {51{8'hA5}};

  task automatic chk(string name, logic [511:0] act, logic [511:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic waitc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csLow(int i);
    cs[i] = 1'b0;
    waitc(2);
  endtask

  task automatic sendBits(int i, logic [543:0] v, int n);
    for (int b = n - 1; b >= 0; b--) begin
      if (cpha[i] == 0) begin
        mosi[i] = v[b];
        waitc(2);
        sclk[i] = (cpol[i] == 0);
        waitc(2);
        sclk[i] = (cpol[i] != 0);
      end else begin
        sclk[i] = (cpol[i] == 0);
        mosi[i] = v[b];
        waitc(2);
        sclk[i] = (cpol[i] != 0);
        waitc(2);
      end
    end
  endtask

  // kind: -1 no event, 0 frame accepted, 1 length error, 2 overrun, 3 crc error
  task automatic csHigh(int i, int k, logic [511:0] d, bit ackEval);
    exp_t r;
    waitc(2);
    cs[i] = 1'b1;
    if (k == 0) begin
      expFc[i]++;
      expValid[i] = 1'b1;
      expData[i] = d;
    end else if (k > 0) expEc[i]++;
    r.inst = i;
    r.kind = k;
    r.due = cyc + 4;
    r.data = expData[i];
    r.fc = expFc[i];
    r.ec = expEc[i];
    r.valid = expValid[i];
    if (k >= 0) sb.push_back(r);
    if (ackEval) begin
      waitc(3);
      ack[i] = 1'b1;
      waitc(1);
      ack[i] = 1'b0;
    end
    waitc(8);
  endtask

  task automatic frame(int i, logic [543:0] v, int n, int k, logic [511:0] d, bit ackEval);
    csLow(i);
    sendBits(i, v, n);
    csHigh(i, k, d, ackEval);
  endtask

  task automatic doAck(int i);
    ack[i] = 1'b1;
    waitc(1);
    ack[i] = 1'b0;
    expValid[i] = 1'b0;
    chk($sformatf("u%0d valid cleared by ack", i), 512'(fvalid[i]), 512'(0));
  endtask

  task automatic resetState(string tag);
    chk({tag, " data"}, fdata[0], '0);
    chk({tag, " valid"}, 512'(fvalid[0]), 512'(0));
    chk({tag, " frame_cnt"}, 512'(fcnt[0]), 512'(0));
    chk({tag, " err_cnt"}, 512'(ecnt[0]), 512'(0));
    for (int i = 0; i < 4; i++) begin
      expFc[i] = 0;
      expEc[i] = 0;
      expValid[i] = 1'b0;
      expData[i] = '0;
    end
  endtask

  // scoreboard monitor: any accepted frame or error pulse must match the oldest expectation
  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (rst) prevCnt[i] = fcnt[i];
      else begin
        kind = (fcnt[i] != prevCnt[i]) ? 0 : elen[i] ? 1 : eovr[i] ? 2 : ecrc[i] ? 3 : -1;
        prevCnt[i] = fcnt[i];
        if (kind >= 0) begin
          if (sb.size() == 0) chk($sformatf("u%0d unexpected event kind", i), 512'(kind), 512'(-1));
          else begin
            e = sb.pop_front();
            chk("event instance", 512'(i), 512'(e.inst));
            chk($sformatf("u%0d event kind", i), 512'(kind), 512'(e.kind));
            chk($sformatf("u%0d event cycle", i), 512'(cyc), 512'(e.due));
            chk($sformatf("u%0d frame data", i), fdata[i], e.data);
            chk($sformatf("u%0d frame_cnt", i), 512'(fcnt[i]), 512'(e.fc));
            chk($sformatf("u%0d err_cnt", i), 512'(ecnt[i]), 512'(e.ec));
            chk($sformatf("u%0d valid", i), 512'(fvalid[i]), 512'(e.valid));
          end
        end
      end
    end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk[i] = (cpol[i] != 0);
      cs[i] = 1'b1;
      mosi[i] = 1'b0;
      ack[i] = 1'b0;
    end
    waitc(3);
    resetState("reset");
    #2 rst = 1'b0;
    waitc(6);
`ifndef SPI_FRAME_CRC_EN
    frame(0, 544'(T1), 408, 0, 512'(T1), 1'b0);
    doAck(0);
    frame(0, 544'({T1, 1'b1}), 409, 1, '0, 1'b0);
    frame(0, 544'(T1), 407, 1, '0, 1'b0);
    chk("err_cnt after two length errors", 512'(ecnt[0]), 512'(2));
    chk("valid after length errors", 512'(fvalid[0]), 512'(0));
    frame(0, 544'(FA), 408, 0, 512'(FA), 1'b0);
    frame(0, 544'(FB), 408, 2, '0, 1'b0);
    chk("data kept across overrun", fdata[0], 512'(FA));
    frame(0, 544'(FC), 408, 0, 512'(FC), 1'b1);
    chk("valid after ack-in-eval load", 512'(fvalid[0]), 512'(1));
    doAck(0);
    csLow(0);
    sendBits(0, 544'(FB >> 208), 200);
    @(negedge clk);
    #2 rst = 1'b1;
    waitc(2);
    #2 rst = 1'b0;
    resetState("mid-frame reset");
    sendBits(0, 544'(FB), 208);
    csHigh(0, -1, '0, 1'b0);
    chk("valid after partial frame", 512'(fvalid[0]), 512'(0));
    frame(0, 544'(FC), 408, 0, 512'(FC), 1'b0);
    doAck(0);
    frame(1, 544'(F5), 408, 0, 512'(F5), 1'b0);
    frame(2, 544'(F5), 408, 0, 512'(F5), 1'b0);
    csLow(0);
    csHigh(0, -1, '0, 1'b0);
    frame(3, 544'(16'h0102), 16, 0, 512'(16'h0102), 1'b0);
    doAck(3);
    frame(3, 544'(24'h01021B), 24, 1, '0, 1'b0);
`else
    frame(3, 544'(24'h01021B), 24, 0, 512'(16'h0102), 1'b0);
    doAck(3);
    frame(3, 544'(24'h01021C), 24, 3, '0, 1'b0);
    chk("frame_cnt after crc error", 512'(fcnt[3]), 512'(1));
`endif
    waitc(10);
    chk("scoreboard drained", 512'(sb.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
